multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Parametrised multicycle RISC-V (RV64I subset) control unit; next generation of the core control FSM.
//  Decodes instr from IR, sequences FETCH/DECODE/EXEC/MEM/WB and drives all datapath load/select/ALU controls.
//  Adds over the previous unit: memory ready handshake with timeout, AND/OR/LUI/JAL, funct3-correct BEQ/BNE.
//  Sits between the instruction register/ALU zero flag and the datapath registers, muxes and memories.
// PARAMETERS
//  ALU_OP_W     3   width of alu_op; codes are defined in ctrl_pkg
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready in a memory state (must be >=1)
//  TMO_W        $clog2(MEM_TIMEOUT+1)  wait-counter width (derived, do not override)
// PORTS
//  clk           in   1         clock, all state on posedge
//  rst           in   1         synchronous reset, active-high
//  instr         in   32        IR contents (valid from DECODE onward)
//  alu_zero      in   1         ALU zero flag, combinational from datapath
//  mem_ready     in   1         memory access complete this cycle
//  pc_write      out  1         load PC
//  ir_load       out  1         load IR from memory
//  mem_read      out  1         memory read request
//  mem_write     out  1         memory write request
//  reg_a_load    out  1         load register A
//  reg_b_load    out  1         load register B
//  alu_out_load  out  1         load ALUOut
//  mdr_load      out  1         load memory data register
//  reg_write     out  1         register file write
//  alu_op        out  ALU_OP_W  ALU_PASSB=0 ADD=1 SUB=2 AND=3 OR=4
//  alu_src_a     out  2         0=PC 1=regA 2=oldPC
//  alu_src_b     out  2         0=regB 1=const 4 2=imm
//  pc_src        out  1         0=ALU result 1=ALUOut
//  wb_sel        out  2         0=ALUOut 1=MDR 2=imm (LUI)
//  mem_tmo       out  1         one-cycle pulse: memory wait exceeded MEM_TIMEOUT
//  state_o       out  4         current state encoding (debug)
// BEHAVIOUR
//  Moore outputs decoded from the registered state; only the pc_write term in BRANCH depends on alu_zero.
//  Outputs not listed per state are 0. Reset: state<=S_RESET, wait counter<=0, every output 0 for one cycle, then FETCH.
//  S_FETCH:   mem_read=1, src_a=0, src_b=1, ADD. Hold while !mem_ready.
//             On mem_ready: ir_load=1, pc_write=1, then -> DECODE.
//  S_DECODE:  reg_a_load=1, reg_b_load=1, src_a=2, src_b=2, ADD, alu_out_load=1 (branch target).
//             Dispatch on instr[6:0]: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> ADDR;
//             1100011 -> BRANCH; 0110111 -> LUI; 1101111 -> JAL; any other -> ILLEGAL handling (see CONFIGURATION).
//  S_EXEC_R:  src_a=1, src_b=0, alu_out_load=1. Op by funct7/funct3: 0000000/000=ADD, 0100000/000=SUB, 111=AND, 110=OR.
//             Then -> WB_ALU.
//  S_EXEC_I:  src_a=1, src_b=2, ADD (funct3 111=AND, 110=OR), alu_out_load=1. Then -> WB_ALU.
//  S_ADDR:    src_a=1, src_b=2, ADD, alu_out_load=1. Load -> MEM_RD, store -> MEM_WR.
//  S_MEM_RD:  mem_read=1; mdr_load=mem_ready. Hold until mem_ready, then -> WB_MEM.
//  S_MEM_WR:  mem_write=1. Hold until mem_ready, then -> FETCH.
//  S_WB_ALU:  reg_write=1, wb_sel=0. Then -> FETCH.   S_WB_MEM: reg_write=1, wb_sel=1. Then -> FETCH.
//  S_BRANCH:  src_a=1, src_b=0, SUB, pc_src=1. pc_write = (f3==000 & alu_zero) | (f3==001 & !alu_zero).
//             Other funct3 values: no PC write. Then -> FETCH.
//  S_LUI:     reg_write=1, wb_sel=2. Then -> FETCH.
//  S_JAL:     pc_write=1, pc_src=1. Then -> FETCH (rd link write is out of scope this generation).
//  Cycle counts with mem_ready held 1: R/I/store = 4, load = 5, branch/LUI/JAL = 3.
//  Wait counter: cleared on entry to any memory state, increments each cycle mem_ready=0.
//  Timeout: when the counter reaches MEM_TIMEOUT, pulse mem_tmo for 1 cycle, abandon the access, go -> FETCH
//  with no write-side effects (no ir_load/pc_write/mdr_load/reg_write).
//  mem_ready on the same cycle as the timeout: ready wins, normal completion, no mem_tmo.
//  rst at any cycle, including mid-wait: abandons the instruction; state and counter reset next edge.
// CONFIGURATION
//  CTRL_TRAP_EN defined:   adds S_TRAP. Illegal opcodes and timeouts enter S_TRAP, which asserts trap (extra 1-bit output).
//                          S_TRAP is sticky until rst.
//  CTRL_TRAP_EN undefined: no trap port. Illegal opcode acts as a NOP (DECODE -> FETCH). Timeout behaves as described above.
// STRUCTURE
//  ctrl_pkg: state_t enum, alu_op codes, opcode/funct3/funct7 localparams, src/wb select encodings.
//  Single module: state register + wait counter (always_ff), next-state and output decode (always_comb).
// TESTING
//  R-type add 0x00208033 with mem_ready=1 -> states FETCH,DECODE,EXEC_R,WB_ALU; alu_op=1; reg_write high in cycle 4.
//  R-type sub 0x40208033 -> alu_op=2 in EXEC_R.
//  beq 0x00208463: alu_zero=1 -> pc_write=1 in BRANCH; alu_zero=0 -> pc_write=0.
//  bne (funct3 001) with alu_zero=0 -> pc_write=1; with alu_zero=1 -> pc_write=0.
//  ld 0x0000B083 with mem_ready low for 3 cycles in MEM_RD -> mdr_load only on the ready cycle; 8 cycles total.
//  sd with mem_ready stuck low -> mem_tmo pulse after 16 wait cycles, then FETCH (or TRAP with CTRL_TRAP_EN).
//  Opcode 0x7F -> NOP back to FETCH; with CTRL_TRAP_EN -> trap=1 held until rst.
//  rst asserted mid MEM_RD -> all outputs 0 the next cycle, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV64I control FSM.
// States, ALU op codes, opcode/funct fields and datapath mux select values.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StReset  = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StExecI  = 4'd4,
    StAddr   = 4'd5,
    StMemRd  = 4'd6,
    StMemWr  = 4'd7,
    StWbAlu  = 4'd8,
    StWbMem  = 4'd9,
    StBranch = 4'd10,
    StLui    = 4'd11,
    StJal    = 4'd12,
    StTrap   = 4'd13
  } state_t;

  localparam logic [2:0] AluPassB = 3'd0;
  localparam logic [2:0] AluAdd   = 3'd1;
  localparam logic [2:0] AluSub   = 3'd2;
  localparam logic [2:0] AluAnd   = 3'd3;
  localparam logic [2:0] AluOr    = 3'd4;

  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Sub    = 7'b0100000;

  localparam logic [1:0] SrcAPc    = 2'd0;
  localparam logic [1:0] SrcARegA  = 2'd1;
  localparam logic [1:0] SrcAOldPc = 2'd2;
  localparam logic [1:0] SrcBRegB  = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] WbAluOut  = 2'd0;
  localparam logic [1:0] WbMdr     = 2'd1;
  localparam logic [1:0] WbImm     = 2'd2;

  // States that wait on mem_ready and are covered by the timeout counter.
  function automatic logic isMemState(state_t s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-to-datapath bundle for the multicycle control FSM.
// The trap output exists only when CTRL_TRAP_EN is defined.
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned ALU_OP_W = 3
);
  logic [31:0]         instr;
  logic                alu_zero;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_load;
  logic                mem_read;
  logic                mem_write;
  logic                reg_a_load;
  logic                reg_b_load;
  logic                alu_out_load;
  logic                mdr_load;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic                pc_src;
  logic [1:0]          wb_sel;
  logic                mem_tmo;
  logic [3:0]          state_o;
`ifdef CTRL_TRAP_EN
  logic                trap;
`endif

  modport master (
    input  instr, alu_zero, mem_ready,
    output pc_write, ir_load, mem_read, mem_write, reg_a_load, reg_b_load, alu_out_load,
    output mdr_load, reg_write, alu_op, alu_src_a, alu_src_b, pc_src, wb_sel, mem_tmo,
    output state_o
`ifdef CTRL_TRAP_EN
    , output trap
`endif
  );

  modport slave (
    output instr, alu_zero, mem_ready,
    input  pc_write, ir_load, mem_read, mem_write, reg_a_load, reg_b_load, alu_out_load,
    input  mdr_load, reg_write, alu_op, alu_src_a, alu_src_b, pc_src, wb_sel, mem_tmo,
    input  state_o
`ifdef CTRL_TRAP_EN
    , input trap
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV64I-subset control FSM with memory-ready timeout.
// Define CTRL_TRAP_EN to add a sticky trap state for illegal opcodes and timeouts.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input logic                   clk,
  input logic                   rst,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(MEM_TIMEOUT);

`ifdef CTRL_TRAP_EN
  localparam state_t FaultState = StTrap;
`else
  localparam state_t FaultState = StFetch;
`endif

  state_t           stateQ, stateD;
  logic [TMO_W-1:0] waitCntQ, waitCntD;
  logic             memWait, timeout;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       unusedInstr;

  logic       pcWrite, irLoad, memRead, memWrite, regALoad, regBLoad;
  logic       aluOutLoad, mdrLoad, regWrite, pcSrc, memTmo;
  logic [2:0] aluOp;
  logic [1:0] aluSrcA, aluSrcB, wbSel;

  assign opcode      = bus.instr[6:0];
  assign funct3      = bus.instr[14:12];
  assign funct7      = bus.instr[31:25];
  assign unusedInstr = ^{bus.instr[24:15], bus.instr[11:7]};

  assign memWait = isMemState(stateQ) && !bus.mem_ready;
  // A ready on the limit cycle still completes normally.
  assign timeout = memWait && (waitCntQ == TmoLimit);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StReset;
      waitCntQ <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
    end
  end

  // Staying in a memory state means still waiting; any exit or timeout clears the count.
  always_comb begin
    waitCntD = '0;
    if (memWait && !timeout) begin
      waitCntD = waitCntQ + TMO_W'(1);
    end
  end

  always_comb begin
    stateD     = stateQ;
    pcWrite    = 1'b0;
    irLoad     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    regALoad   = 1'b0;
    regBLoad   = 1'b0;
    aluOutLoad = 1'b0;
    mdrLoad    = 1'b0;
    regWrite   = 1'b0;
    aluOp      = AluPassB;
    aluSrcA    = SrcAPc;
    aluSrcB    = SrcBRegB;
    pcSrc      = 1'b0;
    wbSel      = WbAluOut;
    memTmo     = 1'b0;

    case (stateQ)
      StReset: stateD = StFetch;

      StFetch: begin
        memRead = 1'b1;
        aluSrcA = SrcAPc;
        aluSrcB = SrcBFour;
        aluOp   = AluAdd;
        if (bus.mem_ready) begin
          irLoad  = 1'b1;
          pcWrite = 1'b1;
          stateD  = StDecode;
        end else if (timeout) begin
          memTmo = 1'b1;
          stateD = FaultState;
        end
      end

      StDecode: begin
        regALoad   = 1'b1;
        regBLoad   = 1'b1;
        aluSrcA    = SrcAOldPc;
        aluSrcB    = SrcBImm;
        aluOp      = AluAdd;
        aluOutLoad = 1'b1;
        case (opcode)
          OpRType:         stateD = StExecR;
          OpIType:         stateD = StExecI;
          OpLoad, OpStore: stateD = StAddr;
          OpBranch:        stateD = StBranch;
          OpLui:           stateD = StLui;
          OpJal:           stateD = StJal;
          default:         stateD = FaultState;
        endcase
      end

      StExecR: begin
        aluSrcA    = SrcARegA;
        aluSrcB    = SrcBRegB;
        aluOutLoad = 1'b1;
        aluOp      = AluAdd;
        if (funct3 == F3And) begin
          aluOp = AluAnd;
        end else if (funct3 == F3Or) begin
          aluOp = AluOr;
        end else if (funct3 == F3AddSub && funct7 == F7Sub) begin
          aluOp = AluSub;
        end else if (funct3 == F3AddSub && funct7 == F7Base) begin
          aluOp = AluAdd;
        end
        stateD = StWbAlu;
      end

      StExecI: begin
        aluSrcA    = SrcARegA;
        aluSrcB    = SrcBImm;
        aluOutLoad = 1'b1;
        aluOp      = (funct3 == F3And) ? AluAnd : (funct3 == F3Or) ? AluOr : AluAdd;
        stateD     = StWbAlu;
      end

      StAddr: begin
        aluSrcA    = SrcARegA;
        aluSrcB    = SrcBImm;
        aluOp      = AluAdd;
        aluOutLoad = 1'b1;
        stateD     = (opcode == OpStore) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        memRead = 1'b1;
        mdrLoad = bus.mem_ready;
        if (bus.mem_ready) begin
          stateD = StWbMem;
        end else if (timeout) begin
          memTmo = 1'b1;
          stateD = FaultState;
        end
      end

      StMemWr: begin
        memWrite = 1'b1;
        if (bus.mem_ready) begin
          stateD = StFetch;
        end else if (timeout) begin
          memTmo = 1'b1;
          stateD = FaultState;
        end
      end

      StWbAlu: begin
        regWrite = 1'b1;
        wbSel    = WbAluOut;
        stateD   = StFetch;
      end

      StWbMem: begin
        regWrite = 1'b1;
        wbSel    = WbMdr;
        stateD   = StFetch;
      end

      StBranch: begin
        aluSrcA = SrcARegA;
        aluSrcB = SrcBRegB;
        aluOp   = AluSub;
        pcSrc   = 1'b1;
        pcWrite = ((funct3 == F3Beq) && bus.alu_zero) || ((funct3 == F3Bne) && !bus.alu_zero);
        stateD  = StFetch;
      end

      StLui: begin
        regWrite = 1'b1;
        wbSel    = WbImm;
        stateD   = StFetch;
      end

      StJal: begin
        pcWrite = 1'b1;
        pcSrc   = 1'b1;
        stateD  = StFetch;
      end

`ifdef CTRL_TRAP_EN
      StTrap: stateD = StTrap;
`endif

      default: stateD = StReset;
    endcase
  end

  assign bus.pc_write     = pcWrite;
  assign bus.ir_load      = irLoad;
  assign bus.mem_read     = memRead;
  assign bus.mem_write    = memWrite;
  assign bus.reg_a_load   = regALoad;
  assign bus.reg_b_load   = regBLoad;
  assign bus.alu_out_load = aluOutLoad;
  assign bus.mdr_load     = mdrLoad;
  assign bus.reg_write    = regWrite;
  assign bus.alu_op       = ALU_OP_W'(aluOp);
  assign bus.alu_src_a    = aluSrcA;
  assign bus.alu_src_b    = aluSrcB;
  assign bus.pc_src       = pcSrc;
  assign bus.wb_sel       = wbSel;
  assign bus.mem_tmo      = memTmo;
  assign bus.state_o      = stateQ;
`ifdef CTRL_TRAP_EN
  assign bus.trap         = (stateQ == StTrap);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: expected per-cycle control vectors are built
// from the instruction-level behaviour and compared against the DUT outputs each cycle.
module tb_multicycle_ctrl_fsm;

  localparam int MemTimeout = 16;

  typedef struct packed {
    logic       pcw, irl, mrd, mwr, ra, rb, aol, mdr, rw;
    logic [2:0] op;
    logic [1:0] sa, sb;
    logic       ps;
    logic [1:0] wb;
    logic       tmo, trap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.ALU_OP_W(3)) bus ();

  multicycle_ctrl_fsm #(
    .ALU_OP_W   (3),
    .MEM_TIMEOUT(MemTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  vec_t        expQ[$];
  vec_t        gotQ[$];
  logic        rdyQ[$];
  logic        zQ[$];
  logic [31:0] insQ[$];
  int          nCmp = 0;
  int          nErr = 0;
  bit          trapped = 0;

  function automatic vec_t sample();
    vec_t v;
    v.pcw = bus.pc_write;   v.irl = bus.ir_load;      v.mrd = bus.mem_read;
    v.mwr = bus.mem_write;  v.ra = bus.reg_a_load;    v.rb = bus.reg_b_load;
    v.aol = bus.alu_out_load; v.mdr = bus.mdr_load;   v.rw = bus.reg_write;
    v.op = bus.alu_op;      v.sa = bus.alu_src_a;     v.sb = bus.alu_src_b;
    v.ps = bus.pc_src;      v.wb = bus.wb_sel;        v.tmo = bus.mem_tmo;
`ifdef CTRL_TRAP_EN
    v.trap = bus.trap;
`else
    v.trap = 1'b0;
`endif
    return v;
  endfunction

  task automatic push(input vec_t v, input logic r, input logic [31:0] ins, input logic z);
    expQ.push_back(v);
    rdyQ.push_back(r);
    insQ.push_back(ins);
    zQ.push_back(z);
  endtask

  task automatic clear_q();
    expQ.delete(); gotQ.delete(); rdyQ.delete(); zQ.delete(); insQ.delete();
  endtask

  // An abandoned instruction either falls back to fetch or, with traps, sticks in trap.
  task automatic abandon();
`ifdef CTRL_TRAP_EN
    vec_t v;
    v = '0;
    v.trap = 1'b1;
    for (int i = 0; i < 3; i++) push(v, 1'(i), 32'(i), 1'b0);
    trapped = 1;
`endif
  endtask

  // Reference behaviour: expected outputs for one instruction starting in fetch.
  // fWait / mWait: cycles mem_ready stays low in fetch / the data access.
  task automatic add_instr(input logic [31:0] ins, input int fWait, input int mWait,
                           input logic z);
    vec_t       v;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    v = '0; v.mrd = 1; v.op = 3'd1; v.sa = 2'd0; v.sb = 2'd1;
    for (int i = 0; i < fWait && i < MemTimeout; i++) push(v, 1'b0, $urandom, 1'($urandom));
    if (fWait > MemTimeout) begin
      v.tmo = 1;
      push(v, 1'b0, $urandom, 1'($urandom));
      abandon();
      return;
    end
    v.pcw = 1; v.irl = 1;
    push(v, 1'b1, $urandom, 1'($urandom));
    v = '0; v.ra = 1; v.rb = 1; v.aol = 1; v.op = 3'd1; v.sa = 2'd2; v.sb = 2'd2;
    push(v, 1'($urandom), ins, 1'($urandom));
    case (opc)
      7'b0110011, 7'b0010011: begin
        v = '0; v.sa = 2'd1; v.aol = 1;
        v.sb = (opc == 7'b0110011) ? 2'd0 : 2'd2;
        if (f3 == 3'b111) v.op = 3'd3;
        else if (f3 == 3'b110) v.op = 3'd4;
        else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'h20) v.op = 3'd2;
        else v.op = 3'd1;
        push(v, 1'($urandom), ins, 1'($urandom));
        v = '0; v.rw = 1; v.wb = 2'd0;
        push(v, 1'($urandom), ins, 1'($urandom));
      end
      7'b0000011, 7'b0100011: begin
        v = '0; v.sa = 2'd1; v.sb = 2'd2; v.op = 3'd1; v.aol = 1;
        push(v, 1'($urandom), ins, 1'($urandom));
        v = '0;
        if (opc == 7'b0000011) v.mrd = 1;
        else v.mwr = 1;
        for (int i = 0; i < mWait && i < MemTimeout; i++) push(v, 1'b0, ins, 1'($urandom));
        if (mWait > MemTimeout) begin
          v.tmo = 1;
          push(v, 1'b0, ins, 1'($urandom));
          abandon();
          return;
        end
        v.mdr = (opc == 7'b0000011);
        push(v, 1'b1, ins, 1'($urandom));
        if (opc == 7'b0000011) begin
          v = '0; v.rw = 1; v.wb = 2'd1;
          push(v, 1'($urandom), ins, 1'($urandom));
        end
      end
      7'b1100011: begin
        v = '0; v.sa = 2'd1; v.sb = 2'd0; v.op = 3'd2; v.ps = 1;
        v.pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z);
        push(v, 1'($urandom), ins, z);
      end
      7'b0110111: begin
        v = '0; v.rw = 1; v.wb = 2'd2;
        push(v, 1'($urandom), ins, 1'($urandom));
      end
      7'b1101111: begin
        v = '0; v.pcw = 1; v.ps = 1;
        push(v, 1'($urandom), ins, 1'($urandom));
      end
      default: abandon();
    endcase
  endtask

  task automatic drive_cycles(input int n);
    gotQ.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      bus.mem_ready = rdyQ[i];
      bus.alu_zero  = zQ[i];
      bus.instr     = insQ[i];
      @(negedge clk);
      gotQ.push_back(sample());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    trapped = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    nCmp++;
    if (sample() !== vec_t'(0)) begin
      nErr++;
      $display("FAIL reset_held got %h want %h", sample(), vec_t'(0));
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nCmp++;
    if (sample() !== vec_t'(0)) begin
      nErr++;
      $display("FAIL reset_state got %h want %h", sample(), vec_t'(0));
    end
  endtask

  task automatic test_rtype();
    add_instr(32'h00208033, 0, 0, 1'b0);
    add_instr(32'h40208033, 1, 0, 1'b1);
    add_instr(32'h0020F033, 0, 0, 1'b0);
    add_instr(32'h0020E033, 2, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL rtype cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_branch();
    add_instr(32'h00208463, 0, 0, 1'b1);
    add_instr(32'h00208463, 0, 0, 1'b0);
    add_instr(32'h00209463, 0, 0, 1'b0);
    add_instr(32'h00209463, 0, 0, 1'b1);
    add_instr(32'h0020C463, 0, 0, 1'b1);
    add_instr(32'h0020C463, 0, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL branch cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_mem_misc();
    add_instr(32'h0000B083, 0, 3, 1'b0);
    add_instr(32'h0010B023, 0, 0, 1'b0);
    add_instr(32'h0010B023, 1, 2, 1'b0);
    add_instr(32'h00108093, 0, 0, 1'b0);
    add_instr(32'h0010F093, 0, 0, 1'b0);
    add_instr(32'h0010E093, 0, 0, 1'b0);
    add_instr(32'h123450B7, 0, 0, 1'b0);
    add_instr(32'h008000EF, 0, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL mem_misc cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_timeout();
    add_instr(32'h0010B023, 0, 40, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL store_timeout cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
    if (trapped) do_reset();
    // Ready exactly on the limit cycle completes; one more wait cycle times out.
    add_instr(32'h0000B083, 0, MemTimeout, 1'b0);
    add_instr(32'h00208033, MemTimeout, 0, 1'b0);
    add_instr(32'h00208033, MemTimeout + 1, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL tmo_boundary cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
    if (trapped) do_reset();
    add_instr(32'h0000B083, 0, MemTimeout + 1, 1'b0);
    add_instr(32'h00208033, 0, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL load_timeout cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
    if (trapped) do_reset();
  endtask

  task automatic test_illegal();
    add_instr(32'h0000007F, 0, 0, 1'b0);
    add_instr(32'h00208033, 0, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL illegal cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
    if (trapped) do_reset();
  endtask

  task automatic test_rst_mid();
    vec_t want;
    add_instr(32'h0000B083, 0, 10, 1'b0);
    drive_cycles(5);
    for (int i = 0; i < 5; i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL rst_mid_pre cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
    @(posedge clk);
    #1 rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    want = '0;
    want.mrd = 1'b1;
    nCmp++;
    if (sample() !== want) begin
      nErr++;
      $display("FAIL rst_mid_wait got %h want %h", sample(), want);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nCmp++;
    if (sample() !== vec_t'(0)) begin
      nErr++;
      $display("FAIL rst_mid_zero got %h want %h", sample(), vec_t'(0));
    end
    add_instr(32'h0000B083, 0, 0, 1'b0);
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL rst_mid_post cycle %0d got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    logic [6:0]  opcs[8];
    logic [31:0] ins;
    int          fw, mw, sel;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
             7'b1100011, 7'b0110111, 7'b1101111, 7'b1111111};
    for (int k = 0; k < 60; k++) begin
`ifdef CTRL_TRAP_EN
      sel = $urandom_range(0, 6);
`else
      sel = $urandom_range(0, 7);
`endif
      ins = $urandom;
      ins[6:0] = opcs[sel];
      if (sel == 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (sel == 7) ins[6:0] = 7'($urandom_range(0, 127)) | 7'b0001000;
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 4);
`ifndef CTRL_TRAP_EN
      if ($urandom_range(0, 9) == 0) mw = MemTimeout + $urandom_range(0, 2);
`endif
      add_instr(ins, fw, mw, 1'($urandom));
    end
    drive_cycles(expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin
        nErr++;
        $display("FAIL random cycle %0d ins %h got %h want %h", i, insQ[i], gotQ[i], expQ[i]);
      end
    end
    clear_q();
  endtask

  initial begin
    bus.instr     = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_branch();
    test_mem_misc();
    test_timeout();
    test_illegal();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
